// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bundle for fp_addsub_pipe.
// master drives operand beats and receives results; slave is the adder.
interface fp_addsub_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int W = 1 + EXP_W + MANT_W;

  logic         i_VALID;
  logic         i_SUB;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic         o_VALID;
  logic [W-1:0] o_RES;
  logic         o_OVF;
  logic         o_INEXACT;

  modport master (
    output i_VALID, i_SUB, i_A, i_B,
    input  o_VALID, o_RES, o_OVF, o_INEXACT
  );

  modport slave (
    input  i_VALID, i_SUB, i_A, i_B,
    output o_VALID, o_RES, o_OVF, o_INEXACT
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor.
// Stages: unpack/classify/swap, align with guard/round/sticky, add/sub,
// normalise/round/pack. Subnormal inputs are flushed to zero.
// Optional feature: define FP_ADDSUB_RNE_EN for round-to-nearest-even;
// without it the result is truncated (round toward zero).
module fp_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input logic             i_CLK,
  input logic             i_RST_N,
  fp_addsub_pipe_if.slave bus
);
  localparam int W       = 1 + EXP_W + MANT_W;
  localparam int SW      = MANT_W + 4;          // hidden + fraction + G/R/S
  localparam int EXP_INF = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp_t;

  // ---------------- stage 1: unpack, classify, swap ----------------
  fp_t              a_w, b_w, x_w, y_w;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic             special_d;
  logic [W-1:0]     spec_res_d;
  logic [EXP_W-1:0] d_d;

  // Classify operands, order them by magnitude and resolve special cases.
  // NOTE: every variable gets a default at the top of a combinational block so no path can infer a latch.
  always_comb begin
    a_w        = fp_t'(bus.i_A);
    b_w        = fp_t'(bus.i_B);
    b_w.sign   = bus.i_B[W-1] ^ bus.i_SUB;
    a_zero     = (a_w.exp == '0);
    b_zero     = (b_w.exp == '0);
    a_inf      = (a_w.exp == EXP_MAX) && (a_w.frac == '0);
    b_inf      = (b_w.exp == EXP_MAX) && (b_w.frac == '0);
    a_nan      = (a_w.exp == EXP_MAX) && (a_w.frac != '0);
    b_nan      = (b_w.exp == EXP_MAX) && (b_w.frac != '0);
    if (a_zero) a_w.frac = '0;
    if (b_zero) b_w.frac = '0;
    swap       = {b_w.exp, b_w.frac} > {a_w.exp, a_w.frac};
    x_w        = swap ? b_w : a_w;
    y_w        = swap ? a_w : b_w;
    d_d        = x_w.exp - y_w.exp;
    special_d  = 1'b1;
    spec_res_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_w.sign != b_w.sign)))
      spec_res_d = QNAN;
    else if (a_inf)
      spec_res_d = {a_w.sign, EXP_MAX, {MANT_W{1'b0}}};
    else if (b_inf)
      spec_res_d = {b_w.sign, EXP_MAX, {MANT_W{1'b0}}};
    else if (a_zero && b_zero)
      spec_res_d = {a_w.sign & b_w.sign, {(W-1){1'b0}}};  // only (-0)+(-0) is negative
    else
      special_d  = 1'b0;
  end

  logic             s1_special_q, s1_sign_q, s1_sub_q;
  logic [W-1:0]     s1_spec_q;
  logic [EXP_W-1:0] s1_exp_q, s1_d_q;
  logic [MANT_W:0]  s1_mx_q, s1_my_q;

  // ---------------- stage 2: align smaller significand ----------------
  logic [SW-1:0] y_ext, lost_mask, y_sh_d;

  // Shift Y right by d, folding every shifted-out bit into the sticky LSB.
  always_comb begin
    y_ext     = {s1_my_q, 3'b000};
    lost_mask = '0;
    if (int'(s1_d_q) >= MANT_W + 3) begin
      y_sh_d = {{(SW-1){1'b0}}, |s1_my_q};
    end else begin
      lost_mask = ~({SW{1'b1}} << s1_d_q);
      y_sh_d    = (y_ext >> s1_d_q) | {{(SW-1){1'b0}}, |(y_ext & lost_mask)};
    end
  end

  logic             s2_special_q, s2_sign_q, s2_sub_q;
  logic [W-1:0]     s2_spec_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_mx_q, s2_my_q;

  // ---------------- stage 3: add / subtract ----------------
  logic [SW:0] sum_d;

  // X has the larger magnitude, so the difference never goes negative.
  always_comb begin
    if (s2_sub_q) sum_d = {1'b0, s2_mx_q} - {1'b0, s2_my_q};
    else          sum_d = {1'b0, s2_mx_q} + {1'b0, s2_my_q};
  end

  logic             s3_special_q, s3_sign_q;
  logic [W-1:0]     s3_spec_q;
  logic [EXP_W-1:0] s3_exp_q;
  logic [SW:0]      s3_sum_q;

  // ---------------- stage 4: normalise, round, pack ----------------
  logic [SW-1:0]   norm;
  logic [MANT_W+1:0] mant_r;
  logic            g, r, s, inc, ovf_d, inexact_d;
  logic [W-1:0]    res_d;
  int              msb, exp_i;

  // Normalise to 1.f, round on G/R/S and pack, catching overflow/underflow.
  always_comb begin
    norm      = '0;
    mant_r    = '0;
    msb       = 0;
    exp_i     = 0;
    {g, r, s} = 3'b000;
    inc       = 1'b0;
    ovf_d     = 1'b0;
    inexact_d = 1'b0;
    res_d     = '0;
    if (s3_special_q) begin
      res_d = s3_spec_q;
    end else if (s3_sum_q != '0) begin       // exact cancellation keeps +0
      if (s3_sum_q[SW]) begin
        norm  = {s3_sum_q[SW:2], s3_sum_q[1] | s3_sum_q[0]};
        exp_i = int'(s3_exp_q) + 1;
      end else begin
        for (int i = 0; i < SW; i++)
          if (s3_sum_q[i]) msb = i;
        norm  = s3_sum_q[SW-1:0] << (SW - 1 - msb);
        exp_i = int'(s3_exp_q) - (SW - 1 - msb);
      end
      {g, r, s} = norm[2:0];
      inexact_d = g | r | s;
`ifdef FP_ADDSUB_RNE_EN
      inc = g & (r | s | norm[3]);
`else
      inc = 1'b0;
`endif
      mant_r = {1'b0, norm[SW-1:3]} + {{(MANT_W+1){1'b0}}, inc};
      if (mant_r[MANT_W+1]) exp_i = exp_i + 1;  // fraction wraps to zero
      if (exp_i <= 0) begin
        res_d     = {s3_sign_q, {(W-1){1'b0}}};
        inexact_d = 1'b1;
      end else if (exp_i >= EXP_INF) begin
        res_d     = {s3_sign_q, EXP_MAX, {MANT_W{1'b0}}};
        ovf_d     = 1'b1;
        inexact_d = 1'b1;
      end else begin
        res_d = {s3_sign_q, exp_i[EXP_W-1:0], mant_r[MANT_W-1:0]};
      end
    end
  end

  // Datapath stage registers; contents only matter when the matching valid bit is set.
  // NOTE: datapath registers carry no reset; only the valid bits and outputs need a defined value.
  always_ff @(posedge i_CLK) begin
    s1_special_q <= special_d;
    s1_spec_q    <= spec_res_d;
    s1_sign_q    <= x_w.sign;
    s1_sub_q     <= x_w.sign ^ y_w.sign;
    s1_exp_q     <= x_w.exp;
    s1_d_q       <= d_d;
    s1_mx_q      <= {x_w.exp != '0, x_w.frac};
    s1_my_q      <= {y_w.exp != '0, y_w.frac};
    s2_special_q <= s1_special_q;
    s2_spec_q    <= s1_spec_q;
    s2_sign_q    <= s1_sign_q;
    s2_sub_q     <= s1_sub_q;
    s2_exp_q     <= s1_exp_q;
    s2_mx_q      <= {s1_mx_q, 3'b000};
    s2_my_q      <= y_sh_d;
    s3_special_q <= s2_special_q;
    s3_spec_q    <= s2_spec_q;
    s3_sign_q    <= s2_sign_q;
    s3_exp_q     <= s2_exp_q;
    s3_sum_q     <= sum_d;
  end

  logic [2:0]   v_q;
  logic         o_valid_q, o_ovf_q, o_inexact_q;
  logic [W-1:0] o_res_q;

  // Valid shift chain and output registers; results hold between valid beats.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      v_q         <= '0;
      o_valid_q   <= 1'b0;
      o_res_q     <= '0;
      o_ovf_q     <= 1'b0;
      o_inexact_q <= 1'b0;
    end else begin
      v_q       <= {v_q[1:0], bus.i_VALID};
      o_valid_q <= v_q[2];
      if (v_q[2]) begin
        o_res_q     <= res_d;
        o_ovf_q     <= ovf_d;
        o_inexact_q <= inexact_d;
      end
    end
  end

  assign bus.o_VALID   = o_valid_q;
  assign bus.o_RES     = o_res_q;
  assign bus.o_OVF     = o_ovf_q;
  assign bus.o_INEXACT = o_inexact_q;
endmodule
